// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks in-flight predicted branches in a circular queue,
// flags mispredictions with a redirect pulse and retires branches in order to train the predictor.
module branch_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_pred_taken,
  input  logic [31:0]      alloc_pred_target,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             update,
  output logic [31:0]      update_pc,
  output logic             update_taken,
  output logic [31:0]      update_target,
  output logic [TAG_W:0]   count
);

  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  logic [DEPTH-1:0] pred_taken_q, act_taken_q;
  logic [31:0]      pc_q          [DEPTH];
  logic [31:0]      pred_target_q [DEPTH];
  logic [31:0]      act_target_q  [DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic             mispredict_q;
  logic [31:0]      redirect_pc_q;
  logic             update_q;
  logic [31:0]      update_pc_q;
  logic             update_taken_q;
  logic [31:0]      update_target_q;

  logic             res_accept;
  logic             res_wrong;
  logic             squash_now;
  logic             retire;
  logic             alloc_fire;
  logic [TAG_W-1:0] res_off;

  // Distance of a tag from the oldest entry; larger means younger.
  function automatic logic [TAG_W-1:0] ageOf(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] h);
    return t - h;
  endfunction

  assign alloc_ready = (count_q != CNT_FULL);
  assign alloc_tag   = tail_q;
  assign count       = count_q;

  assign res_accept = res_valid && valid_q[res_tag] && !resolved_q[res_tag];
  assign res_wrong  = (pred_taken_q[res_tag] != res_taken) ||
                      (res_taken && (pred_target_q[res_tag] != res_target));
  assign squash_now = res_accept && res_wrong;
  assign retire     = valid_q[head_q] && resolved_q[head_q];
  assign alloc_fire = alloc_valid && alloc_ready && !squash_now;
  assign res_off    = ageOf(res_tag, head_q);

  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (retire) begin
      valid_d[head_q]    = 1'b0;
      resolved_d[head_q] = 1'b0;
      head_d             = head_q + TAG_ONE;
    end
    if (res_accept) begin
      resolved_d[res_tag] = 1'b1;
    end
    if (squash_now) begin
      // Everything fetched after the mispredicted branch is on the wrong path.
      for (int i = 0; i < DEPTH; i++) begin
        if (ageOf(TAG_W'(i), head_q) > res_off) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
      tail_d  = res_tag + TAG_ONE;
      count_d = {1'b0, res_off} + CNT_ONE - {{TAG_W{1'b0}}, retire};
    end else begin
      if (alloc_fire) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + TAG_ONE;
      end
      count_d = count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, retire};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= '0;
      resolved_q      <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      update_q        <= 1'b0;
      update_pc_q     <= '0;
      update_taken_q  <= 1'b0;
      update_target_q <= '0;
    end else begin
      valid_q      <= valid_d;
      resolved_q   <= resolved_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mispredict_q <= squash_now;
      update_q     <= retire;
      if (squash_now) begin
        redirect_pc_q <= res_taken ? res_target : (pc_q[res_tag] + 32'd4);
      end
      if (retire) begin
        update_pc_q     <= pc_q[head_q];
        update_taken_q  <= act_taken_q[head_q];
        update_target_q <= act_target_q[head_q];
      end
    end
  end

  // Payload storage needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_q]          <= alloc_pc;
      pred_taken_q[tail_q]  <= alloc_pred_taken;
      pred_target_q[tail_q] <= alloc_pred_target;
    end
    if (res_accept) begin
      act_taken_q[res_tag]  <= res_taken;
      act_target_q[res_tag] <= res_target;
    end
  end

  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;
  assign update        = update_q;
  assign update_pc     = update_pc_q;
  assign update_taken  = update_taken_q;
  assign update_target = update_target_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios followed by random traffic,
// all checked against an in-order list model of the in-flight branches.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [31:0] alloc_pc;
  logic        alloc_pred_taken;
  logic [31:0] alloc_pred_target;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        res_valid;
  logic [2:0]  res_tag;
  logic        res_taken;
  logic [31:0] res_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        update;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic [3:0]  count;

  branch_resolve_unit #(.DEPTH(8), .TAG_W(3)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc),
    .alloc_pred_taken(alloc_pred_taken), .alloc_pred_target(alloc_pred_target),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .update(update), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  tag;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        res;
    logic        at;
    logic [31:0] atgt;
  } ent_t;

  // Oldest branch at the front; the list itself is the program order.
  ent_t        mq[$];
  logic [2:0]  mtail;
  logic        expMis, expUpd, expUpdTaken, afterReset;
  logic [31:0] expRedir, expUpdPc, expUpdTgt;
  int          compared = 0;
  int          mismatched = 0;

  task automatic checkVal(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mtail = 3'd0;
    expMis = 1'b0; expUpd = 1'b0; expUpdTaken = 1'b0;
    expRedir = '0; expUpdPc = '0; expUpdTgt = '0;
    afterReset = 1'b1;
  endtask

  task automatic checkOutput();
    checkVal("mispredict", {31'd0, mispredict}, {31'd0, expMis});
    checkVal("update", {31'd0, update}, {31'd0, expUpd});
    checkVal("count", {28'd0, count}, mq.size());
    checkVal("alloc_ready", {31'd0, alloc_ready}, {31'd0, mq.size() != 8});
    checkVal("alloc_tag", {29'd0, alloc_tag}, {29'd0, mtail});
    if (expMis || afterReset)
      checkVal("redirect_pc", redirect_pc, expRedir);
    if (expUpd || afterReset) begin
      checkVal("update_pc", update_pc, expUpdPc);
      checkVal("update_taken", {31'd0, update_taken}, {31'd0, expUpdTaken});
      checkVal("update_target", update_target, expUpdTgt);
    end
  endtask

  task automatic applyModel(input logic r, input logic av, input logic [31:0] apc, input logic apt,
                            input logic [31:0] aptgt, input logic rv, input logic [2:0] rtag,
                            input logic rt, input logic [31:0] rtgt);
    int   sz;
    logic doRetire, squash;
    ent_t retired, e;
    logic [31:0] redir;
    if (r) begin
      modelReset();
      return;
    end
    afterReset = 1'b0;
    sz = mq.size();
    doRetire = (sz > 0) && mq[0].res;
    retired = '0;
    if (doRetire) retired = mq[0];
    squash = 1'b0;
    redir = '0;
    if (rv) begin
      for (int k = 0; k < sz; k++) begin
        if (mq[k].tag == rtag && !mq[k].res) begin
          e = mq[k];
          e.res = 1'b1; e.at = rt; e.atgt = rtgt;
          mq[k] = e;
          if ((e.pt != rt) || (rt && e.ptgt != rtgt)) begin
            squash = 1'b1;
            redir = rt ? rtgt : e.pc + 32'd4;
            while (mq.size() > k + 1) void'(mq.pop_back());
            mtail = rtag + 3'd1;
          end
          break;
        end
      end
    end
    if (av && sz != 8 && !squash) begin
      e = '0;
      e.tag = mtail; e.pc = apc; e.pt = apt; e.ptgt = aptgt;
      mq.push_back(e);
      mtail = mtail + 3'd1;
    end
    if (doRetire) void'(mq.pop_front());
    expMis = squash;
    if (squash) expRedir = redir;
    expUpd = doRetire;
    if (doRetire) begin
      expUpdPc = retired.pc; expUpdTaken = retired.at; expUpdTgt = retired.atgt;
    end
  endtask

  // One clock cycle: check state-derived outputs, drive inputs, advance model, wait.
  task automatic applyStimulus(input logic r, input logic av, input logic [31:0] apc, input logic apt,
                               input logic [31:0] aptgt, input logic rv, input logic [2:0] rtag,
                               input logic rt, input logic [31:0] rtgt);
    checkOutput();
    rst = r; alloc_valid = av; alloc_pc = apc; alloc_pred_taken = apt; alloc_pred_target = aptgt;
    res_valid = rv; res_tag = rtag; res_taken = rt; res_target = rtgt;
    applyModel(r, av, apc, apt, aptgt, rv, rtag, rt, rtgt);
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 3'd0, 1'b0, '0);
  endtask
  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 3'd0, 1'b0, '0);
  endtask
  task automatic doAlloc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    applyStimulus(1'b0, 1'b1, pc, pt, tgt, 1'b0, 3'd0, 1'b0, '0);
  endtask
  task automatic doResolve(input logic [2:0] tag, input logic t, input logic [31:0] tgt);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, tag, t, tgt);
  endtask

  initial begin
    logic        av, apt, rv, rt, r;
    logic [31:0] apc, aptgt, rtgt;
    logic [2:0]  rtag;
    ent_t        pick;

    rst = 1'b1; alloc_valid = 1'b0; alloc_pc = '0; alloc_pred_taken = 1'b0; alloc_pred_target = '0;
    res_valid = 1'b0; res_tag = '0; res_taken = 1'b0; res_target = '0;
    modelReset();
    @(negedge clk);
    idle();
    idle();

    // Correctly predicted branch retires and trains the predictor.
    doAlloc(32'h100, 1'b1, 32'h200);
    doResolve(3'd0, 1'b1, 32'h200);
    checkVal("no_mispredict", {31'd0, mispredict}, 32'd0);
    idle();
    checkVal("upd_pulse", {31'd0, update}, 32'd1);
    checkVal("upd_pc_100", update_pc, 32'h100);
    checkVal("upd_tgt_200", update_target, 32'h200);
    idle();

    // Not-taken prediction resolved taken squashes younger branches.
    doReset();
    doAlloc(32'h40, 1'b0, 32'h0);
    doAlloc(32'h44, 1'b0, 32'h0);
    doAlloc(32'h48, 1'b1, 32'h90);
    doResolve(3'd0, 1'b1, 32'h80);
    checkVal("mis_pulse", {31'd0, mispredict}, 32'd1);
    checkVal("redir_80", redirect_pc, 32'h80);
    checkVal("squash_count", {28'd0, count}, 32'd1);
    checkVal("squash_tag", {29'd0, alloc_tag}, 32'd1);
    doResolve(3'd2, 1'b1, 32'h90);
    idle();
    idle();

    // Direction and target mispredictions.
    doReset();
    doAlloc(32'h300, 1'b1, 32'h400);
    doResolve(3'd0, 1'b0, 32'h0);
    checkVal("redir_304", redirect_pc, 32'h304);
    idle();
    doAlloc(32'h300, 1'b1, 32'h400);
    doResolve(3'd1, 1'b1, 32'h500);
    checkVal("redir_500", redirect_pc, 32'h500);
    idle();
    idle();

    // Full queue, out-of-order resolve, in-order retire, pointer wrap.
    doReset();
    for (int i = 0; i < 8; i++) doAlloc(32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0);
    checkVal("full_ready", {31'd0, alloc_ready}, 32'd0);
    doAlloc(32'h2000, 1'b0, 32'h0);
    checkVal("full_count", {28'd0, count}, 32'd8);
    doResolve(3'd3, 1'b0, 32'h0);
    doResolve(3'd0, 1'b0, 32'h0);
    idle();
    doResolve(3'd1, 1'b0, 32'h0);
    doResolve(3'd2, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) idle();
    checkVal("wrap_tag", {29'd0, alloc_tag}, 32'd0);
    doAlloc(32'h3000, 1'b1, 32'h3100);
    doAlloc(32'h3004, 1'b0, 32'h0);

    // Reset wins over a pending retire, mispredict and alloc.
    doReset();
    doAlloc(32'h500, 1'b0, 32'h0);
    doAlloc(32'h504, 1'b0, 32'h0);
    doResolve(3'd0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h600, 1'b0, '0, 1'b1, 3'd1, 1'b1, 32'h700);
    checkVal("rst_mis", {31'd0, mispredict}, 32'd0);
    checkVal("rst_upd", {31'd0, update}, 32'd0);
    checkVal("rst_count", {28'd0, count}, 32'd0);

    // Random traffic against the list model.
    for (int n = 0; n < 800; n++) begin
      r     = ($urandom_range(0, 99) == 0);
      av    = ($urandom_range(0, 99) < 55);
      apc   = {$urandom_range(0, 32'hFFFF), 2'b00};
      apt   = $urandom_range(0, 1) == 1;
      aptgt = {$urandom_range(0, 32'hFFFF), 2'b00};
      rv    = 1'b0; rtag = 3'd0; rt = 1'b0; rtgt = '0;
      if (mq.size() > 0 && $urandom_range(0, 99) < 50) begin
        pick = mq[$urandom_range(0, mq.size() - 1)];
        rv   = 1'b1;
        rtag = pick.tag;
        rt   = ($urandom_range(0, 3) != 0) ? pick.pt : !pick.pt;
        rtgt = ($urandom_range(0, 3) != 0) ? pick.ptgt : {$urandom_range(0, 32'hFFFF), 2'b00};
      end else if ($urandom_range(0, 9) == 0) begin
        rv   = 1'b1;
        rtag = 3'($urandom_range(0, 7));
        rt   = $urandom_range(0, 1) == 1;
        rtgt = {$urandom_range(0, 32'hFFFF), 2'b00};
      end
      applyStimulus(r, av, apc, apt, aptgt, rv, rtag, rt, rtgt);
    end
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Feedback end of the branch prediction interface, between fetch/issue and the branch functional unit / CDB.
- Records each in-flight branch's prediction in a circular queue and returns a tag. Compares resolved outcomes against the recorded prediction.
- On a mismatch, raises a one-cycle redirect and squashes younger branches.
- Retires resolved branches in program order and drives the predictor's update/update_taken/update_target training port.

Parameters:
- DEPTH, 8, in-flight branch entries (power of 2, ≥2)
- TAG_W, 3, tag width = log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  fetch issues a predicted branch this cycle
- alloc_pc  in  32  branch PC
- alloc_pred_taken  in  1  predictor taken output captured at fetch
- alloc_pred_target  in  32  predictor target output captured at fetch
- alloc_ready  out  1  queue can accept (combinational: count != DEPTH)
- alloc_tag  out  TAG_W  tag assigned to the current alloc (= tail pointer)
- res_valid  in  1  branch unit resolves a branch
- res_tag  in  TAG_W  tag being resolved
- res_taken  in  1  actual direction
- res_target  in  32  actual taken target
- mispredict  out  1  registered one-cycle flush/redirect pulse
- redirect_pc  out  32  correct next PC, valid with mispredict
- update  out  1  registered one-cycle training pulse to predictor
- update_pc  out  32  PC of retiring branch (for predictor index mux)
- update_taken  out  1  actual direction of retiring branch
- update_target  out  32  actual target of retiring branch
- count  out  TAG_W+1  occupied entries

Behaviour:
- Reset (sync, rst=1 at posedge):
  - head=tail=count=0; all valid/resolved bits cleared.
  - mispredict=0, update=0, redirect_pc=0, update_pc=0, update_taken=0, update_target=0.
  - Reset overrides any concurrent alloc/res.
- Queue entry fields: valid, resolved, pc, pred_taken, pred_target, act_taken, act_target.
- Alloc:
  - Accepted when alloc_valid && alloc_ready && !squash_now.
  - Writes the entry at tail with valid=1, resolved=0. tail+1 mod DEPTH.
  - alloc_valid with alloc_ready=0 is dropped; no state change.
- Resolve (cycle N):
  - Ignored if res_valid=0 or entry[res_tag].valid=0 or entry already resolved.
  - Otherwise sets resolved=1 and stores act_taken/act_target.
  - wrong = (pred_taken != res_taken) || (res_taken && pred_target != res_target).
- Mispredict (squash_now = accepted resolve with wrong=1):
  - Cycle N+1: mispredict=1, redirect_pc = res_taken ? res_target : pc+4 (32-bit wrap).
  - At the N edge: all entries strictly younger than res_tag are invalidated, tail <= res_tag+1 mod DEPTH, count recomputed = ((res_tag - head) mod DEPTH) + 1.
  - Any alloc in cycle N is discarded (its fetch path is being flushed).
  - Correct prediction: no pulse.
- Retire:
  - Each cycle, if entry[head].valid && resolved (state as of the start of the cycle): head+1, entry invalidated, count-1.
  - Next cycle: update=1 with update_pc/taken/target from that entry.
  - Update is emitted for every retired branch, whether predicted correctly or not.
  - Max one retire per cycle. Earliest update for a branch resolved in cycle N is N+2.
- Simultaneous events:
  - Alloc + retire in the same cycle: count unchanged.
  - Retire + mispredict on a younger tag: both occur; count = new span minus the retired entry.
  - Mispredict on head tag while head is retiring that cycle is impossible (head not yet resolved).
- Wrap-around: pointers are mod DEPTH. Full vs empty is distinguished by count only.
- Full: alloc_ready=0. A squash or retire in cycle N reopens space visibly in cycle N+1.
- Pulses mispredict/update deassert after one cycle unless retriggered.

Test Plan:
- Reset then idle: all outputs 0, count=0, alloc_ready=1, alloc_tag=0.
- Alloc pc=0x100 pred_taken=1 target=0x200 (tag 0); resolve tag0 taken=1 target=0x200 at N → no mispredict; at N+2 update=1, update_pc=0x100, update_taken=1, update_target=0x200; count back to 0.
- Alloc pc=0x40 pred_taken=0 (tag0), then tags 1,2; resolve tag0 taken=1 target=0x80 → N+1 mispredict=1, redirect_pc=0x80; count=1, alloc_tag=1; a late resolve on tag2 is ignored.
- Resolve predicted-taken 0x300 target=0x400 as not taken → redirect_pc=0x304. Same PC predicted taken to 0x400, actual target 0x500 → mispredict, redirect_pc=0x500.
- Fill 8 entries: alloc_ready=0, a 9th alloc is dropped. Resolve tags 3 then 0 → updates emitted in order tag0 only until tags 1,2 resolve, then 1,2,3 on consecutive cycles. Pointers wrap to tag 0 on the next allocs.
- rst asserted with a mispredicting resolve and alloc pending → next cycle mispredict=0, update=0, count=0.
